sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 151 +++++++++++++++
 tb/tb_sram_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single-port 512x8 SRAM macro.
// Optional clear sweep after reset, round-robin or fixed-priority grant,
// registered SRAM pins one cycle after accept, read data two cycles after accept.
module sram_arbiter #(
    parameter logic CLEAR_ON_RESET = 1'b1,
    parameter logic FIXED_PRIO     = 1'b0
) (
    input  logic       clk,
    input  logic       rst,

    input  logic       p0_valid,
    output logic       p0_ready,
    input  logic       p0_we,
    input  logic [8:0] p0_addr,
    input  logic [7:0] p0_wdata,
    input  logic [7:0] p0_wmask,
    output logic       p0_rvalid,
    output logic [7:0] p0_rdata,

    input  logic       p1_valid,
    output logic       p1_ready,
    input  logic       p1_we,
    input  logic [8:0] p1_addr,
    input  logic [7:0] p1_wdata,
    input  logic [7:0] p1_wmask,
    output logic       p1_rvalid,
    output logic [7:0] p1_rdata,

    output logic [8:0] sram_a,
    output logic [7:0] sram_d,
    output logic [7:0] sram_wen,
    output logic       sram_gwen,
    output logic       sram_cen,
    input  logic [7:0] sram_q,

    output logic       init_done
);

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0] r_state;
    logic [9:0] r_init_cnt;     // bit 9 set once address 511 has been issued
    logic       r_init_done;
    logic       r_last;         // port that won the most recent transfer
    logic [1:0] r_rd1;          // read issued to pins this cycle, per port
    logic [1:0] r_rd2;          // read data on sram_q this cycle, per port
    logic [8:0] r_sram_a;
    logic [7:0] r_sram_d;
    logic [7:0] r_sram_wen;
    logic       r_sram_gwen;
    logic       r_sram_cen;

    logic       w_run;
    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_xfer;
    logic       w_sel;
    logic       w_we;
    logic [8:0] w_addr;
    logic [7:0] w_wdata;
    logic [7:0] w_wmask;

    // Grant selection; ready is combinational and suppressed during reset and the clear sweep.
    always_comb begin
        w_run = (r_state == S_RUN) && !rst;
        if (FIXED_PRIO) begin
            w_gnt0 = p0_valid;
            w_gnt1 = p1_valid && !p0_valid;
        end else begin
            w_gnt0 = p0_valid && (!p1_valid || r_last);
            w_gnt1 = p1_valid && (!p0_valid || !r_last);
        end
        p0_ready = w_run && w_gnt0;
        p1_ready = w_run && w_gnt1;
        w_xfer   = p0_ready || p1_ready;
        w_sel    = p1_ready;
        w_we     = w_sel ? p1_we    : p0_we;
        w_addr   = w_sel ? p1_addr  : p0_addr;
        w_wdata  = w_sel ? p1_wdata : p0_wdata;
        w_wmask  = w_sel ? p1_wmask : p0_wmask;
    end

    // State, clear sweep, SRAM pin registers and read-return pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= CLEAR_ON_RESET ? S_INIT : S_RUN;
            r_init_cnt  <= 10'd0;
            r_init_done <= !CLEAR_ON_RESET;
            r_last      <= 1'b1;
            r_rd1       <= 2'b00;
            r_rd2       <= 2'b00;
            r_sram_a    <= 9'd0;
            r_sram_d    <= 8'h00;
            r_sram_wen  <= 8'hFF;
            r_sram_gwen <= 1'b1;
            r_sram_cen  <= 1'b1;
        end else begin
            r_rd2 <= r_rd1;
            r_rd1 <= {w_xfer && !w_we && w_sel, w_xfer && !w_we && !w_sel};
            if (r_state == S_INIT) begin
                if (!r_init_cnt[9]) begin
                    r_sram_a    <= r_init_cnt[8:0];
                    r_sram_d    <= 8'h00;
                    r_sram_wen  <= 8'h00;
                    r_sram_gwen <= 1'b0;
                    r_sram_cen  <= 1'b0;
                    r_init_cnt  <= r_init_cnt + 10'd1;
                end else begin
                    // Address 511 is on the pins this cycle; usable from the next one.
                    r_state     <= S_RUN;
                    r_init_done <= 1'b1;
                    r_sram_wen  <= 8'hFF;
                    r_sram_gwen <= 1'b1;
                    r_sram_cen  <= 1'b1;
                end
            end else if (w_xfer) begin
                r_last     <= w_sel;
                r_sram_cen <= 1'b0;
                r_sram_a   <= w_addr;
                if (w_we) begin
                    r_sram_gwen <= 1'b0;
                    r_sram_wen  <= ~w_wmask;
                    r_sram_d    <= w_wdata;
                end else begin
                    r_sram_gwen <= 1'b1;
                    r_sram_wen  <= 8'hFF;
                end
            end else begin
                r_sram_cen  <= 1'b1;
                r_sram_gwen <= 1'b1;
                r_sram_wen  <= 8'hFF;
            end
        end
    end

    // Outputs: pins straight from registers, read data gated to zero outside rvalid.
    always_comb begin
        sram_a    = r_sram_a;
        sram_d    = r_sram_d;
        sram_wen  = r_sram_wen;
        sram_gwen = r_sram_gwen;
        sram_cen  = r_sram_cen;
        p0_rvalid = r_rd2[0];
        p1_rvalid = r_rd2[1];
        p0_rdata  = r_rd2[0] ? sram_q : 8'h00;
        p1_rdata  = r_rd2[1] ? sram_q : 8'h00;
        init_done = r_init_done && !rst;
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench: instance A uses defaults (clear sweep, round-robin),
// instance B uses CLEAR_ON_RESET=0, FIXED_PRIO=1. Each has its own SRAM model.
module tb_sram_arbiter;

    logic clk;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Instance A signals
    logic       rst;
    logic       p0_valid, p0_we, p1_valid, p1_we;
    logic [8:0] p0_addr, p1_addr;
    logic [7:0] p0_wdata, p0_wmask, p1_wdata, p1_wmask;
    logic       p0_ready, p1_ready, p0_rvalid, p1_rvalid;
    logic [7:0] p0_rdata, p1_rdata;
    logic [8:0] sram_a;
    logic [7:0] sram_d, sram_wen, sram_q;
    logic       sram_gwen, sram_cen, init_done;

    // Instance B signals
    logic       rst_b;
    logic       p0_valid_b, p0_we_b, p1_valid_b, p1_we_b;
    logic [8:0] p0_addr_b, p1_addr_b;
    logic [7:0] p0_wdata_b, p0_wmask_b, p1_wdata_b, p1_wmask_b;
    logic       p0_ready_b, p1_ready_b, p0_rvalid_b, p1_rvalid_b;
    logic [7:0] p0_rdata_b, p1_rdata_b;
    logic [8:0] sram_a_b;
    logic [7:0] sram_d_b, sram_wen_b, sram_q_b;
    logic       sram_gwen_b, sram_cen_b, init_done_b;

    sram_arbiter dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_wmask(p0_wmask), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_wmask(p1_wmask), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .sram_a(sram_a), .sram_d(sram_d), .sram_wen(sram_wen), .sram_gwen(sram_gwen),
        .sram_cen(sram_cen), .sram_q(sram_q), .init_done(init_done)
    );

    sram_arbiter #(.CLEAR_ON_RESET(1'b0), .FIXED_PRIO(1'b1)) dut_b (
        .clk(clk), .rst(rst_b),
        .p0_valid(p0_valid_b), .p0_ready(p0_ready_b), .p0_we(p0_we_b), .p0_addr(p0_addr_b),
        .p0_wdata(p0_wdata_b), .p0_wmask(p0_wmask_b), .p0_rvalid(p0_rvalid_b), .p0_rdata(p0_rdata_b),
        .p1_valid(p1_valid_b), .p1_ready(p1_ready_b), .p1_we(p1_we_b), .p1_addr(p1_addr_b),
        .p1_wdata(p1_wdata_b), .p1_wmask(p1_wmask_b), .p1_rvalid(p1_rvalid_b), .p1_rdata(p1_rdata_b),
        .sram_a(sram_a_b), .sram_d(sram_d_b), .sram_wen(sram_wen_b), .sram_gwen(sram_gwen_b),
        .sram_cen(sram_cen_b), .sram_q(sram_q_b), .init_done(init_done_b)
    );

    // Behavioural single-port SRAM macros, pre-filled with a non-zero pattern.
    logic [7:0] mem_a [512];
    logic [7:0] mem_b [512];
    initial begin
        for (int i = 0; i < 512; i++) begin
            mem_a[i] = 8'h5A;
            mem_b[i] = 8'h5A;
        end
        sram_q   = 8'h00;
        sram_q_b = 8'h00;
    end
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen) mem_a[sram_a] <= (mem_a[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else            sram_q <= mem_a[sram_a];
        end
        if (!sram_cen_b) begin
            if (!sram_gwen_b) mem_b[sram_a_b] <= (mem_b[sram_a_b] & sram_wen_b) | (sram_d_b & ~sram_wen_b);
            else              sram_q_b <= mem_b[sram_a_b];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [22:0] got, exp;
        step();
        step();
        p0_valid = 1'b1;
        p1_valid = 1'b1;
        #1;
        n_checks++;
        if ({sram_cen, sram_gwen, sram_wen, sram_a, sram_d} !== {1'b1, 1'b1, 8'hFF, 9'd0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_pins: got cen=%b gwen=%b wen=%h a=%h d=%h, expected 1 1 ff 000 00",
                     sram_cen, sram_gwen, sram_wen, sram_a, sram_d);
        end
        n_checks++;
        if ({p0_ready, p1_ready, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata, init_done} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b%b rv=%b%b rd=%h/%h done=%b, expected all zero",
                     p0_ready, p1_ready, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata, init_done);
        end
        rst = 1'b0;
        for (int k = 0; k < 512; k++) begin
            step();
            #1;
            got = {sram_cen, sram_gwen, sram_wen, sram_d, p0_ready, p1_ready, init_done, 3'b000};
            exp = 23'd0;
            n_checks++;
            if (got !== exp || sram_a !== 9'(k)) begin
                n_fail++;
                $display("FAIL sweep_%0d: got cen=%b gwen=%b wen=%h d=%h a=%h rdy=%b%b done=%b, expected 0 0 00 00 a=%h rdy=00 done=0",
                         k, sram_cen, sram_gwen, sram_wen, sram_d, sram_a, p0_ready, p1_ready, init_done, 9'(k));
            end
        end
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        step();
        #1;
        n_checks++;
        if ({init_done, sram_cen} !== 2'b11) begin
            n_fail++;
            $display("FAIL init_done_rise: got done=%b cen=%b, expected done=1 cen=1", init_done, sram_cen);
        end
    endtask

    task automatic test_round_robin();
        int g;
        for (int i = 0; i < 8; i++) begin
            step();
            p0_valid = (i < 6); p0_we = 1'b0; p0_addr = 9'h100 + 9'(i);
            p1_valid = (i < 6); p1_we = 1'b0; p1_addr = 9'h180 + 9'(i);
            #1;
            g = p0_ready ? 0 : (p1_ready ? 1 : 2);
            if (i < 6) begin
                n_checks++;
                if ((p0_ready && p1_ready) || g != (i % 2)) begin
                    n_fail++;
                    $display("FAIL rr_grant_%0d: got ready=%b%b, expected port %0d", i, p0_ready, p1_ready, i % 2);
                end
            end
            n_checks++;
            if (i >= 2) begin
                if (p0_rvalid !== ((i % 2) == 0) || p1_rvalid !== ((i % 2) == 1) ||
                    p0_rdata !== 8'h00 || p1_rdata !== 8'h00) begin
                    n_fail++;
                    $display("FAIL rr_rvalid_%0d: got rv=%b%b rd=%h/%h, expected rv port %0d rd 00/00",
                             i, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata, i % 2);
                end
            end else if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_rvalid_%0d: got rv=%b%b, expected 00", i, p0_rvalid, p1_rvalid);
            end
        end
    endtask

    task automatic test_write_read();
        step();
        p0_valid = 1'b1; p0_we = 1'b1; p0_addr = 9'h1FF; p0_wdata = 8'hA5; p0_wmask = 8'hFF;
        #1;
        n_checks++;
        if (p0_ready !== 1'b1) begin
            n_fail++; $display("FAIL wr_accept: got ready=%b, expected 1", p0_ready);
        end
        step();
        p0_we = 1'b0;
        #1;
        n_checks++;
        if ({sram_cen, sram_gwen, sram_wen, sram_a, sram_d, p0_ready} !== {1'b0, 1'b0, 8'h00, 9'h1FF, 8'hA5, 1'b1}) begin
            n_fail++;
            $display("FAIL wr_pins: got cen=%b gwen=%b wen=%h a=%h d=%h rdy=%b, expected 0 0 00 1ff a5 1",
                     sram_cen, sram_gwen, sram_wen, sram_a, sram_d, p0_ready);
        end
        step();
        p0_valid = 1'b0;
        #1;
        n_checks++;
        if ({sram_cen, sram_gwen, sram_wen, sram_a, p0_rvalid} !== {1'b0, 1'b1, 8'hFF, 9'h1FF, 1'b0}) begin
            n_fail++;
            $display("FAIL rd_pins: got cen=%b gwen=%b wen=%h a=%h rv=%b, expected 0 1 ff 1ff 0",
                     sram_cen, sram_gwen, sram_wen, sram_a, p0_rvalid);
        end
        step();
        #1;
        n_checks++;
        if ({p0_rvalid, p0_rdata, p1_rvalid, p1_rdata} !== {1'b1, 8'hA5, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL rd_return: got p0 rv=%b rd=%h p1 rv=%b rd=%h, expected p0 1 a5 p1 0 00",
                     p0_rvalid, p0_rdata, p1_rvalid, p1_rdata);
        end
        n_checks++;
        if ({sram_cen, sram_gwen, sram_wen} !== {1'b1, 1'b1, 8'hFF}) begin
            n_fail++;
            $display("FAIL idle_pins: got cen=%b gwen=%b wen=%h, expected 1 1 ff", sram_cen, sram_gwen, sram_wen);
        end
        step();
        #1;
        n_checks++;
        if ({p0_rvalid, p0_rdata} !== {1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL rd_single_pulse: got rv=%b rd=%h, expected 0 00", p0_rvalid, p0_rdata);
        end
    endtask

    task automatic test_masked_write();
        step();
        p0_valid = 1'b1; p0_we = 1'b1; p0_addr = 9'h010; p0_wdata = 8'hFF; p0_wmask = 8'hFF;
        step();
        p0_wdata = 8'h00; p0_wmask = 8'h0F;
        step();
        p0_wdata = 8'h55; p0_wmask = 8'h00;
        #1;
        n_checks++;
        if ({sram_cen, sram_gwen, sram_wen, sram_d} !== {1'b0, 1'b0, 8'hF0, 8'h00}) begin
            n_fail++;
            $display("FAIL masked_pins: got cen=%b gwen=%b wen=%h d=%h, expected 0 0 f0 00",
                     sram_cen, sram_gwen, sram_wen, sram_d);
        end
        step();
        p0_we = 1'b0;
        #1;
        n_checks++;
        if ({sram_cen, sram_gwen, sram_wen, sram_d} !== {1'b0, 1'b0, 8'hFF, 8'h55}) begin
            n_fail++;
            $display("FAIL zero_mask_pins: got cen=%b gwen=%b wen=%h d=%h, expected 0 0 ff 55",
                     sram_cen, sram_gwen, sram_wen, sram_d);
        end
        step();
        p0_valid = 1'b0;
        step();
        #1;
        n_checks++;
        if ({p0_rvalid, p0_rdata} !== {1'b1, 8'hF0}) begin
            n_fail++;
            $display("FAIL masked_read: got rv=%b rd=%h, expected 1 f0", p0_rvalid, p0_rdata);
        end
    endtask

    task automatic test_reset_mid_read();
        step();
        p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 9'h010;
        #1;
        n_checks++;
        if (p0_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_rd_accept: got ready=%b, expected 1", p0_ready);
        end
        step();
        p0_valid = 1'b0;
        p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 9'h011;
        rst = 1'b1;
        #1;
        n_checks++;
        if (p1_ready !== 1'b0) begin
            n_fail++; $display("FAIL ready_in_reset: got ready=%b, expected 0", p1_ready);
        end
        step();
        p1_valid = 1'b0;
        #1;
        n_checks++;
        if ({p0_rvalid, p1_rvalid, sram_cen, sram_a, sram_d, sram_wen, init_done} !==
            {1'b0, 1'b0, 1'b1, 9'd0, 8'h00, 8'hFF, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset_state: got rv=%b%b cen=%b a=%h d=%h wen=%h done=%b, expected 00 1 000 00 ff 0",
                     p0_rvalid, p1_rvalid, sram_cen, sram_a, sram_d, sram_wen, init_done);
        end
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            #1;
            n_checks++;
            if ({sram_cen, sram_gwen, sram_a, p0_rvalid, p1_rvalid} !== {1'b0, 1'b0, 9'(k), 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL restart_sweep_%0d: got cen=%b gwen=%b a=%h rv=%b%b, expected 0 0 %h 00",
                         k, sram_cen, sram_gwen, sram_a, p0_rvalid, p1_rvalid, 9'(k));
            end
        end
    endtask

    task automatic test_no_clear();
        step();
        #1;
        n_checks++;
        if ({init_done_b, p0_ready_b, sram_cen_b} !== {1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL nc_reset: got done=%b rdy=%b cen=%b, expected 0 0 1", init_done_b, p0_ready_b, sram_cen_b);
        end
        step();
        rst_b = 1'b0;
        p0_valid_b = 1'b1; p0_we_b = 1'b1; p0_addr_b = 9'h005; p0_wdata_b = 8'h3C; p0_wmask_b = 8'hFF;
        #1;
        n_checks++;
        if ({init_done_b, p0_ready_b} !== 2'b11) begin
            n_fail++;
            $display("FAIL nc_first_cycle: got done=%b rdy=%b, expected 1 1", init_done_b, p0_ready_b);
        end
        step();
        p0_we_b = 1'b0;
        #1;
        n_checks++;
        if ({sram_cen_b, sram_gwen_b, sram_a_b, sram_d_b} !== {1'b0, 1'b0, 9'h005, 8'h3C}) begin
            n_fail++;
            $display("FAIL nc_wr_pins: got cen=%b gwen=%b a=%h d=%h, expected 0 0 005 3c",
                     sram_cen_b, sram_gwen_b, sram_a_b, sram_d_b);
        end
        step();
        p0_valid_b = 1'b0;
        step();
        #1;
        n_checks++;
        if ({p0_rvalid_b, p0_rdata_b} !== {1'b1, 8'h3C}) begin
            n_fail++;
            $display("FAIL nc_read: got rv=%b rd=%h, expected 1 3c", p0_rvalid_b, p0_rdata_b);
        end
    endtask

    task automatic test_fixed_prio();
        for (int i = 0; i < 8; i++) begin
            step();
            p0_valid_b = (i < 6); p0_we_b = 1'b0; p0_addr_b = 9'h005;
            p1_valid_b = (i < 6); p1_we_b = 1'b0; p1_addr_b = 9'h006;
            #1;
            if (i < 6) begin
                n_checks++;
                if ({p0_ready_b, p1_ready_b} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL fp_grant_%0d: got ready=%b%b, expected 10", i, p0_ready_b, p1_ready_b);
                end
            end
            if (i >= 2) begin
                n_checks++;
                if ({p0_rvalid_b, p0_rdata_b, p1_rvalid_b} !== {1'b1, 8'h3C, 1'b0}) begin
                    n_fail++;
                    $display("FAIL fp_rvalid_%0d: got p0 rv=%b rd=%h p1 rv=%b, expected 1 3c 0",
                             i, p0_rvalid_b, p0_rdata_b, p1_rvalid_b);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; rst_b = 1'b1;
        p0_valid = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0; p0_wmask = 0;
        p1_valid = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0; p1_wmask = 0;
        p0_valid_b = 0; p0_we_b = 0; p0_addr_b = 0; p0_wdata_b = 0; p0_wmask_b = 0;
        p1_valid_b = 0; p1_we_b = 0; p1_addr_b = 0; p1_wdata_b = 0; p1_wmask_b = 0;
        test_reset();
        test_round_robin();
        test_write_read();
        test_masked_write();
        test_reset_mid_read();
        test_no_clear();
        test_fixed_prio();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
